// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and scoreboard for the 32x(2R/1W) register file.
// Optional forwarding from the write stage is enabled by the WB_BYPASS_EN macro.
module regfile_wb_sched #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_addr,
  input  logic [DW-1:0]   mem_data,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_wb,
  output logic            stall,
  output logic            write_enable,
  output logic [AW-1:0]   addr3,
  output logic [DW-1:0]   wdata,
  output logic [NREG-1:0] busy_vec
`ifdef WB_BYPASS_EN
  ,
  output logic            fwd1,
  output logic            fwd2
`endif
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic            ptr_mem;
  logic            grant_p0;
  logic [AW-1:0]   grant_addr_p0;
  logic [DW-1:0]   grant_data_p0;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] busy_eff;

  // Stage p0: round-robin grant; ptr_mem=1 means the load channel wins a tie
  always_comb begin
    alu_ready     = alu_valid & (~mem_valid | ~ptr_mem);
    mem_ready     = mem_valid & (~alu_valid | ptr_mem);
    grant_p0      = alu_ready | mem_ready;
    grant_addr_p0 = alu_ready ? alu_addr : mem_addr;
    grant_data_p0 = alu_ready ? alu_data : mem_data;
  end

  always_comb begin
    clr_vec  = write_enable ? (ONE << addr3) : '0;
`ifdef WB_BYPASS_EN
    busy_eff = busy_vec & ~clr_vec;
    fwd1     = write_enable & (addr3 == iss_rs1) & (iss_rs1 != '0);
    fwd2     = write_enable & (addr3 == iss_rs2) & (iss_rs2 != '0);
`else
    busy_eff = busy_vec;
`endif
    busy_eff[0] = 1'b0;
    stall    = iss_valid & (busy_eff[iss_rs1] | busy_eff[iss_rs2] |
                            (iss_wb & busy_eff[iss_rd]));
    set_vec  = (iss_valid & ~stall & iss_wb & (iss_rd != '0)) ? (ONE << iss_rd) : '0;
  end

  // Stage p1: register-file write port and scoreboard update
  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable <= 1'b0;
      addr3        <= '0;
      wdata        <= '0;
      busy_vec     <= '0;
      ptr_mem      <= 1'b0;
    end else begin
      write_enable <= grant_p0 & (grant_addr_p0 != '0);
      if (grant_p0) begin
        addr3   <= grant_addr_p0;
        wdata   <= grant_data_p0;
        ptr_mem <= alu_ready;
      end
      busy_vec <= ((busy_vec & ~clr_vec) | set_vec) & ~ONE;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched; follows WB_BYPASS_EN for forwarding timing.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_addr, mem_addr, iss_rs1, iss_rs2, iss_rd, addr3;
  logic [31:0] alu_data, mem_data, wdata, busy_vec;
  logic        iss_valid, iss_wb, stall, write_enable;
`ifdef WB_BYPASS_EN
  logic        fwd1, fwd2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_wb(iss_wb), .stall(stall), .write_enable(write_enable), .addr3(addr3),
    .wdata(wdata), .busy_vec(busy_vec)
`ifdef WB_BYPASS_EN
    , .fwd1(fwd1), .fwd2(fwd2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wb);
    iss_valid = v; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_wb = wb;
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    issue(0, 0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;

    // reset state and idle
    chk("rst_we", write_enable, 0);
    chk("rst_addr3", addr3, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy_vec, 0);
    issue(1, 3, 3, 3, 0);
    #1 chk("idle_stall", stall, 0);
    tick();

    // RAW hazard on r5 resolved by an ALU write-back
    issue(1, 0, 0, 5, 1);
    #1 chk("iss_rd5_stall", stall, 0);
    tick();
    chk("busy5_set", busy_vec, 32'h20);
    issue(1, 5, 0, 0, 0);
    alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
    #1;
    chk("raw_stall_t", stall, 1);
    chk("alu_ready_t", alu_ready, 1);
    chk("mem_ready_t", mem_ready, 0);
    tick();
    alu_valid = 0;
    chk("we_t1", write_enable, 1);
    chk("addr3_t1", addr3, 5);
    chk("wdata_t1", wdata, 32'hDEADBEEF);
    #1;
`ifdef WB_BYPASS_EN
    chk("stall_t1_byp", stall, 0);
    chk("fwd1_t1", fwd1, 1);
    chk("fwd2_t1", fwd2, 0);
`else
    chk("stall_t1", stall, 1);
`endif
    tick();
    chk("we_t2", write_enable, 0);
    chk("busy_t2", busy_vec, 0);
    #1 chk("stall_t2", stall, 0);
    issue(0, 0, 0, 0, 0);

    // round-robin with both channels valid
    rst = 1; tick(); rst = 0;
    alu_valid = 1; alu_addr = 7; alu_data = 32'h77;
    mem_valid = 1; mem_addr = 8; mem_data = 32'h88;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rr_alu_ready", alu_ready, (i != 1));
      chk("rr_mem_ready", mem_ready, (i == 1));
      tick();
      chk("rr_we", write_enable, 1);
      chk("rr_addr3", addr3, (i == 1) ? 8 : 7);
      chk("rr_wdata", wdata, (i == 1) ? 32'h88 : 32'h77);
    end
    alu_valid = 0; mem_valid = 0;
    tick();
    chk("rr_idle_we", write_enable, 0);
    chk("rr_idle_addr3", addr3, 7);
    chk("rr_busy", busy_vec, 0);

    // write to r0 is accepted but suppressed
    mem_valid = 1; mem_addr = 0; mem_data = 32'h1234;
    #1 chk("r0_mem_ready", mem_ready, 1);
    tick();
    mem_valid = 0;
    chk("r0_we", write_enable, 0);
    chk("r0_busy", busy_vec, 0);

    // set and clear of r9 on the same edge
    issue(1, 0, 0, 9, 1);
    tick();
    issue(0, 0, 0, 0, 0);
    chk("busy9_set", busy_vec, 32'h200);
    alu_valid = 1; alu_addr = 9; alu_data = 32'h99;
    tick();
    alu_valid = 0;
    chk("we9", write_enable, 1);
    chk("addr3_9", addr3, 9);
    issue(1, 0, 0, 9, 1);
#1;
`ifdef WB_BYPASS_EN
    chk("waw9_stall", stall, 0);
    tick();
    chk("setwins_busy", busy_vec, 32'h200);
`else
    chk("waw9_stall", stall, 1);
    tick();
    chk("clr9_busy", busy_vec, 0);
`endif
    issue(0, 0, 0, 0, 0);

    // mid-operation reset drops state and in-flight grant
    issue(1, 0, 0, 4, 1);
    tick();
    issue(0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
    chk("busy4_set", busy_vec, 32'h210);
`else
    chk("busy4_set", busy_vec, 32'h10);
`endif
    rst = 1;
    alu_valid = 1; alu_addr = 6; alu_data = 32'h66;
    mem_valid = 1; mem_addr = 6; mem_data = 32'h66;
    tick();
    rst = 0;
    chk("mrst_we", write_enable, 0);
    chk("mrst_busy", busy_vec, 0);
    issue(1, 4, 0, 0, 0);
    #1;
    chk("mrst_stall", stall, 0);
    chk("mrst_ptr_alu", alu_ready, 1);
    chk("mrst_ptr_mem", mem_ready, 0);
    tick();
    alu_valid = 0; mem_valid = 0;
    issue(0, 0, 0, 0, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
